// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// The optional MADD op (md_op 111) is only enabled when MD_MADD_EN is defined.
package md_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_MULT  = 3'b001,
    OP_MULTU = 3'b010,
    OP_DIV   = 3'b011,
    OP_DIVU  = 3'b100,
    OP_MTHI  = 3'b101,
    OP_MTLO  = 3'b110,
    OP_MADD  = 3'b111
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam logic READ_LO = 1'b0;
  localparam logic READ_HI = 1'b1;

  localparam int DEFAULT_MULT_LAT = 5;
  localparam int DEFAULT_DIV_LAT  = 10;

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit {hi,lo} result for MULT/MULTU/DIV/DIVU (and MADD when MD_MADD_EN).
// Divide by zero and non-arithmetic ops return the current {hi,lo} so a commit leaves them unchanged.
module md_arith
  import md_pkg::*;
(
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [2:0]  md_op,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0] sprod;
  logic [63:0] uprod;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] div_b;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] squot;
  logic [31:0] srem;
  logic [31:0] uquot;
  logic [31:0] urem;
  logic        b_zero;

  assign sprod = $signed({{32{operand_a[31]}}, operand_a}) * $signed({{32{operand_b[31]}}, operand_b});
  assign uprod = {32'b0, operand_a} * {32'b0, operand_b};

  // Signed divide on magnitudes; 0x80000000 survives negation as its own unsigned magnitude.
  assign b_zero = (operand_b == 32'b0);
  assign abs_a  = operand_a[31] ? (~operand_a + 32'd1) : operand_a;
  assign abs_b  = operand_b[31] ? (~operand_b + 32'd1) : operand_b;
  assign div_b  = b_zero ? 32'd1 : abs_b;
  assign sq_mag = abs_a / div_b;
  assign sr_mag = abs_a % div_b;
  assign squot  = (operand_a[31] ^ operand_b[31]) ? (~sq_mag + 32'd1) : sq_mag;
  assign srem   = operand_a[31] ? (~sr_mag + 32'd1) : sr_mag;
  assign uquot  = operand_a / (b_zero ? 32'd1 : operand_b);
  assign urem   = operand_a % (b_zero ? 32'd1 : operand_b);

  always_comb begin
    result = {hi, lo};
    case (md_op_e'(md_op))
      OP_MULT:  result = sprod;
      OP_MULTU: result = uprod;
      OP_DIV:   if (!b_zero) result = {srem, squot};
      OP_DIVU:  if (!b_zero) result = {urem, uquot};
`ifdef MD_MADD_EN
      OP_MADD:  result = {hi, lo} + sprod;
`endif
      default:  result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO, with fixed-latency busy/stall handshake.
// Build option MD_MADD_EN enables the MADD accumulate op (md_op 111).
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no op in flight; accepts MD ops and MTHI/MTLO
// ST_BUSY | result held in pending, counter runs down to commit
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_LAT = DEFAULT_MULT_LAT,
  parameter int DIV_LAT  = DEFAULT_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [2:0]  md_op,
  input  logic        start,
  input  logic        read_sel,
  output logic [31:0] md_out,
  output logic        busy,
  output logic        stall_req
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(1);

  md_state_e        state;
  md_state_e        state_nxt;
  md_op_e           op;
  logic [CNT_W-1:0] counter;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [31:0]      pending_hi;
  logic [31:0]      pending_lo;
  logic [63:0]      arith_res;
  logic             is_mul;
  logic             is_div;
  logic             is_arith;
  logic             issue;
  logic             last_cycle;

  assign op = md_op_e'(md_op);

`ifdef MD_MADD_EN
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD);
`else
  assign is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
  assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
  assign is_arith   = is_mul || is_div;
  assign issue      = (state == ST_IDLE) && start && is_arith;
  assign last_cycle = (state == ST_BUSY) && (counter == CNT_TC);

  md_arith u_arith (
    .operand_a (operand_a),
    .operand_b (operand_b),
    .md_op     (md_op),
    .hi        (hi),
    .lo        (lo),
    .result    (arith_res)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (issue) state_nxt = ST_BUSY;
      ST_BUSY: if (last_cycle) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == ST_BUSY);
    stall_req = busy || (start && is_arith);
    md_out    = (read_sel == READ_HI) ? hi : lo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter    <= '0;
      hi         <= '0;
      lo         <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
    end else if (state == ST_IDLE) begin
      if (issue) begin
        {pending_hi, pending_lo} <= arith_res;
        counter <= is_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      end else if (start && op == OP_MTHI) begin
        hi <= operand_a;
      end else if (start && op == OP_MTLO) begin
        lo <= operand_a;
      end
    end else begin
      counter <= counter - CNT_W'(1);
      if (last_cycle) begin
        hi <= pending_hi;
        lo <= pending_lo;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: stimulus pushes per-cycle expectations, a monitor pops and compares.
// MADD checks follow MD_MADD_EN.
module tb_md_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic [2:0]  md_op;
  logic        start;
  logic        read_sel;
  logic [31:0] md_out;
  logic        busy;
  logic        stall_req;

  md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .md_op     (md_op),
    .start     (start),
    .read_sel  (read_sel),
    .md_out    (md_out),
    .busy      (busy),
    .stall_req (stall_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    string       name;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  task automatic push(input int due, input string name, input logic b, input logic s,
                      input logic [31:0] h, input logic [31:0] l);
    exp_t e;
    e.due = due; e.name = name; e.busy = b; e.stall = s; e.hi = h; e.lo = l;
    q.push_back(e);
  endtask

  // Issue one MD op in the current cycle and queue the expected per-cycle view.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic arith, input int lat,
                       input logic [31:0] new_hi, input logic [31:0] new_lo);
    int t;
    @(negedge clk);
    t = cyc;
    md_op = op; operand_a = a; operand_b = b; start = 1'b1;
    if (arith) begin
      push(t, {name, "_issue"}, 1'b0, 1'b1, m_hi, m_lo);
      for (int k = 1; k <= lat; k++) push(t + k, {name, "_busy"}, 1'b1, 1'b1, m_hi, m_lo);
      push(t + lat + 1, {name, "_done"}, 1'b0, 1'b0, new_hi, new_lo);
      @(negedge clk);
      start = 1'b0; md_op = 3'b000;
      repeat (lat) @(negedge clk);
    end else begin
      push(t, {name, "_issue"}, 1'b0, 1'b0, m_hi, m_lo);
      push(t + 1, {name, "_done"}, 1'b0, 1'b0, new_hi, new_lo);
    end
    m_hi = new_hi; m_lo = new_lo;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; md_op = 3'b000;
    end
  endtask

  task automatic check(input string name, input string what, input logic [31:0] got,
                       input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s %s cyc=%0d got=%h want=%h", name, what, cyc, got, want);
    end
  endtask

  // Monitor owns read_sel and samples both HI and LO mid-cycle.
  initial begin
    logic [31:0] lo_v, hi_v;
    logic        b_v, s_v;
    exp_t        e;
    read_sel = 1'b0;
    forever begin
      @(negedge clk);
      #1 read_sel = 1'b0;
      #1 lo_v = md_out;
      read_sel = 1'b1;
      #1 hi_v = md_out;
      b_v = busy;
      s_v = stall_req;
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        if (e.due < cyc) begin
          n_tests++; n_fail++;
          $display("FAIL %s missed cyc=%0d due=%0d", e.name, cyc, e.due);
        end else begin
          check(e.name, "busy",  {31'b0, b_v}, {31'b0, e.busy});
          check(e.name, "stall", {31'b0, s_v}, {31'b0, e.stall});
          check(e.name, "hi",    hi_v, e.hi);
          check(e.name, "lo",    lo_v, e.lo);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n && start && busy)
      assert (0) else $error("start issued while busy");
  end

  initial begin
    int t;
    int guard;
    reset_n = 1'b0; start = 1'b0; md_op = 3'b000;
    operand_a = 32'h0; operand_b = 32'h0;
    repeat (2) @(negedge clk);
    push(cyc, "reset", 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    issue("mult_neg",  3'b001, 32'hFFFFFFFE, 32'h00000003, 1'b1, MULT_LAT, 32'hFFFFFFFF, 32'hFFFFFFFA);
    issue("multu_max", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, MULT_LAT, 32'hFFFFFFFE, 32'h00000001);
    issue("div_neg",   3'b011, 32'hFFFFFFF9, 32'h00000002, 1'b1, DIV_LAT,  32'hFFFFFFFF, 32'hFFFFFFFD);
    issue("div_posneg",3'b011, 32'h00000007, 32'hFFFFFFFE, 1'b1, DIV_LAT,  32'h00000001, 32'hFFFFFFFD);
    issue("div_ovf",   3'b011, 32'h80000000, 32'hFFFFFFFF, 1'b1, DIV_LAT,  32'h00000000, 32'h80000000);
    issue("divu_zero", 3'b100, 32'h00001234, 32'h00000000, 1'b1, DIV_LAT,  32'h00000000, 32'h80000000);
    issue("divu",      3'b100, 32'd100,      32'd7,        1'b1, DIV_LAT,  32'h00000002, 32'h0000000E);
    issue("mtlo",      3'b110, 32'h12345678, 32'h0,        1'b0, 0,        32'h00000002, 32'h12345678);
    issue("mthi",      3'b101, 32'hCAFEBABE, 32'h0,        1'b0, 0,        32'hCAFEBABE, 32'h12345678);
    issue("none",      3'b000, 32'hDEADBEEF, 32'h0,        1'b0, 0,        32'hCAFEBABE, 32'h12345678);
    idle(1);

    // Reset asserted in the third busy cycle of a DIV.
    @(negedge clk);
    t = cyc;
    md_op = 3'b011; operand_a = 32'd50; operand_b = 32'd3; start = 1'b1;
    push(t, "rst_div_issue", 1'b0, 1'b1, m_hi, m_lo);
    push(t + 1, "rst_div_busy", 1'b1, 1'b1, m_hi, m_lo);
    push(t + 2, "rst_div_busy", 1'b1, 1'b1, m_hi, m_lo);
    @(negedge clk);
    start = 1'b0; md_op = 3'b000;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    push(t + 3, "rst_mid", 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    push(t + 4, "rst_after", 1'b0, 1'b0, 32'h0, 32'h0);
    issue("mult_post", 3'b001, 32'h00000003, 32'h00000004, 1'b1, MULT_LAT, 32'h00000000, 32'h0000000C);

    issue("madd_sethi", 3'b101, 32'h00000000, 32'h0, 1'b0, 0, 32'h00000000, 32'h0000000C);
    issue("madd_setlo", 3'b110, 32'hFFFFFFFF, 32'h0, 1'b0, 0, 32'h00000000, 32'hFFFFFFFF);
`ifdef MD_MADD_EN
    idle(1);
    issue("madd", 3'b111, 32'h00000001, 32'h00000001, 1'b1, MULT_LAT, 32'h00000001, 32'h00000000);
`else
    issue("madd_off", 3'b111, 32'h00000001, 32'h00000001, 1'b0, 0, 32'h00000000, 32'hFFFFFFFF);
`endif
    idle(2);

    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++; n_fail++;
      $display("FAIL %s timeout due=%0d cyc=%0d", e.name, e.due, cyc);
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
